// File: rtl/vlogic_stream.sv
// vlogic_stream: pipelined multi-lane vector logic unit.
// Streams vl elements as LANES-wide beats, applies one of eight bitwise
// operations per element, and merges masked-off and tail elements with the
// old destination value. Results leave through a single registered output
// stage with valid/ready flow control.
module vlogic_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int VLEN_MAX   = 32,
    localparam int VLW       = $clog2(VLEN_MAX) + 1
) (
    input  logic                        module_clk_i,
    input  logic                        module_rst_i,
    input  logic                        start_i,
    input  logic [2:0]                  op_i,
    input  logic [VLW-1:0]              vl_i,
    input  logic                        mask_en_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_i,
    input  logic [LANES*DATA_WIDTH-1:0] old_i,
    input  logic [LANES-1:0]            mask_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0] result_o,
    output logic                        out_last_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [2:0]                    op_r;
    logic [VLW-1:0]                vl_r;
    logic                          mask_en_r;
    logic [VLW-1:0]                beats_left_r;
    logic [VLW-1:0]                elem_base_r;
    logic                          out_valid_r;
    logic                          out_last_r;
    logic [LANES*DATA_WIDTH-1:0]   result_r;
    logic                          done_r;

    logic                          in_ready_s;
    logic                          in_hs_s;
    logic                          out_hs_s;
    logic                          start_ok_s;
    logic [VLW:0]                  beats_calc_s;
    logic [VLW:0]                  elem_idx_s;
    logic [LANES*DATA_WIDTH-1:0]   beat_result_s;

    // Bitwise operation selected by the 3-bit opcode.
    function automatic logic [DATA_WIDTH-1:0] op_fn(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = ~a & b;
            3'd2:    r = a | b;
            3'd3:    r = ~a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~(a & b);
            3'd7:    r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // An input beat moves only when the output stage is empty or draining.
    assign in_ready_s  = (state_r == S_RUN) && (!out_valid_r || out_ready_i);
    assign in_hs_s     = in_valid_i && in_ready_s;
    assign out_hs_s    = out_valid_r && out_ready_i;
    assign start_ok_s  = (state_r == S_IDLE) && start_i;
    // Beat count is ceil(vl/LANES); the extra bit keeps vl+LANES-1 from wrapping.
    assign beats_calc_s = ({1'b0, vl_i} + (VLW+1)'(LANES - 1)) / (VLW+1)'(LANES);

    assign busy_o      = (state_r != S_IDLE);
    assign done_o      = done_r;
    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_last_o  = out_last_r;
    assign result_o    = result_r;

    // Per-lane result: tail and masked-off lanes keep the old destination value.
    always_comb begin
        beat_result_s = '0;
        elem_idx_s    = '0;
        for (int j = 0; j < LANES; j++) begin
            elem_idx_s = {1'b0, elem_base_r} + (VLW+1)'(j);
            if (elem_idx_s >= {1'b0, vl_r}) begin
                beat_result_s[j*DATA_WIDTH +: DATA_WIDTH] = old_i[j*DATA_WIDTH +: DATA_WIDTH];
            end else if (mask_en_r && !mask_i[j]) begin
                beat_result_s[j*DATA_WIDTH +: DATA_WIDTH] = old_i[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                beat_result_s[j*DATA_WIDTH +: DATA_WIDTH] =
                    op_fn(op_r, a_i[j*DATA_WIDTH +: DATA_WIDTH], b_i[j*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Next-state logic for the IDLE/RUN/DRAIN sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i && (vl_i != '0)) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (in_hs_s && (beats_left_r == VLW'(1))) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (out_hs_s && out_last_r) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge module_clk_i) begin
        if (module_rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operation context and beat/element counters, latched at start.
    always_ff @(posedge module_clk_i) begin
        if (module_rst_i) begin
            op_r         <= 3'd0;
            vl_r         <= '0;
            mask_en_r    <= 1'b0;
            beats_left_r <= '0;
            elem_base_r  <= '0;
        end else if (start_ok_s) begin
            op_r         <= op_i;
            vl_r         <= vl_i;
            mask_en_r    <= mask_en_i;
            beats_left_r <= beats_calc_s[VLW-1:0];
            elem_base_r  <= '0;
        end else if (in_hs_s) begin
            if (beats_left_r != '0) begin
                beats_left_r <= beats_left_r - VLW'(1);
            end else begin
                beats_left_r <= '0;
            end
            elem_base_r <= elem_base_r + VLW'(LANES);
        end else begin
            beats_left_r <= beats_left_r;
            elem_base_r  <= elem_base_r;
        end
    end

    // Registered output stage: load on input handshake, empty on output-only handshake.
    always_ff @(posedge module_clk_i) begin
        if (module_rst_i) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            result_r    <= '0;
        end else if (in_hs_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (beats_left_r == VLW'(1));
            result_r    <= beat_result_s;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    // Completion pulse: empty operation, or final beat leaving the output stage.
    always_ff @(posedge module_clk_i) begin
        if (module_rst_i) begin
            done_r <= 1'b0;
        end else if (start_ok_s && (vl_i == '0)) begin
            done_r <= 1'b1;
        end else if ((state_r == S_DRAIN) && out_hs_s && out_last_r) begin
            done_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vlogic_stream.sv
// Directed testbench for vlogic_stream (DATA_WIDTH=32, LANES=4, VLEN_MAX=32).
module tb_vlogic_stream;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [5:0]   vl;
    logic         mask_en;
    logic         busy;
    logic         done;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] old;
    logic [3:0]   mask;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         out_last;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ov_cnt   = 0;
    int last_hs_cyc = 0;
    int done_cyc    = 0;
    logic [127:0] res_q[$];
    logic         last_q[$];

    vlogic_stream #(.DATA_WIDTH(32), .LANES(4), .VLEN_MAX(32)) dut (
        .module_clk_i (clk),
        .module_rst_i (rst),
        .start_i      (start),
        .op_i         (op),
        .vl_i         (vl),
        .mask_en_i    (mask_en),
        .busy_o       (busy),
        .done_o       (done),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a),
        .b_i          (b),
        .old_i        (old),
        .mask_i       (mask),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .out_last_o   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every output handshake and every done pulse.
    always @(negedge clk) begin
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (out_valid && out_ready) begin
            res_q.push_back(result);
            last_q.push_back(out_last);
            if (out_last) last_hs_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [5:0] l, input logic me);
        start = 1'b1; op = o; vl = l; mask_en = me;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] ta, input logic [127:0] tb,
                             input logic [127:0] told, input logic [3:0] tm);
        logic hs;
        int n;
        in_valid = 1'b1; a = ta; b = tb; old = told; mask = tm;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            n++;
        end
        if (!hs) check_eq("beat_accept_timeout", {127'd0, hs}, 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        logic seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!seen) begin
                tick();
                if (done_cnt != d0) seen = 1'b1;
            end
        end
        check_eq("done_seen", {127'd0, seen}, 128'd1);
    endtask

    task automatic clear_q();
        res_q.delete();
        last_q.delete();
    endtask

    initial begin
        int d0;
        int ov0;
        rst = 1'b1; start = 1'b0; op = 3'd0; vl = 6'd0; mask_en = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; old = '0; mask = 4'd0; out_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("rst_busy",      {127'd0, busy},      128'd0);
        check_eq("rst_done",      {127'd0, done},      128'd0);
        check_eq("rst_in_ready",  {127'd0, in_ready},  128'd0);
        check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_eq("rst_out_last",  {127'd0, out_last},  128'd0);
        check_eq("rst_result",    result,              128'd0);
        rst = 1'b0;
        tick();

        // AND, vl=8: two full beats.
        clear_q();
        start_op(3'd0, 6'd8, 1'b0);
        check_eq("and_busy", {127'd0, busy}, 128'd1);
        send_beat({4{32'hF0F0F0F0}}, {4{32'hFF00FF00}}, '0, 4'hF);
        send_beat({4{32'hF0F0F0F0}}, {4{32'hFF00FF00}}, '0, 4'hF);
        wait_done();
        check_eq("and_nbeats", 128'(res_q.size()), 128'd2);
        if (res_q.size() == 2) begin
            check_eq("and_beat1", res_q[0], {4{32'hF000F000}});
            check_eq("and_beat2", res_q[1], {4{32'hF000F000}});
            check_eq("and_last1", {127'd0, last_q[0]}, 128'd0);
            check_eq("and_last2", {127'd0, last_q[1]}, 128'd1);
        end
        check_eq("and_done_latency", 128'(done_cyc - last_hs_cyc), 128'd1);
        check_eq("and_idle_after", {127'd0, busy}, 128'd0);

        // XNOR, vl=6: tail lanes of beat 2 keep old value.
        clear_q();
        start_op(3'd5, 6'd6, 1'b0);
        send_beat('0, '0, {4{32'hDEADBEEF}}, 4'h0);
        send_beat('0, '0, {4{32'hDEADBEEF}}, 4'h0);
        wait_done();
        check_eq("xnor_nbeats", 128'(res_q.size()), 128'd2);
        if (res_q.size() == 2) begin
            check_eq("xnor_beat1", res_q[0], {4{32'hFFFFFFFF}});
            check_eq("xnor_beat2_tail", res_q[1],
                     {32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        end

        // ORN with mask 0101: lanes 1,3 masked off.
        clear_q();
        start_op(3'd3, 6'd4, 1'b1);
        send_beat('0, {4{32'h00000000}}, {4{32'h12345678}}, 4'b0101);
        wait_done();
        check_eq("orn_nbeats", 128'(res_q.size()), 128'd1);
        if (res_q.size() == 1) begin
            check_eq("orn_mask", res_q[0],
                     {32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF});
            check_eq("orn_last", {127'd0, last_q[0]}, 128'd1);
        end

        // OR, vl=12, output stalled for 3 cycles after beat 1.
        clear_q();
        out_ready = 1'b0;
        start_op(3'd2, 6'd12, 1'b0);
        in_valid = 1'b1; a = {4{32'h11111111}}; b = {4{32'h22222222}}; old = '0; mask = 4'hF;
        tick();
        a = {4{32'h0F0F0F0F}}; b = {4{32'hF0F0F0F0}};
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_result",    result,               {4{32'h33333333}});
            check_eq("stall_valid",     {127'd0, out_valid},  128'd1);
            check_eq("stall_in_ready",  {127'd0, in_ready},   128'd0);
            tick();
        end
        out_ready = 1'b1;
        send_beat({4{32'h0F0F0F0F}}, {4{32'hF0F0F0F0}}, '0, 4'hF);
        send_beat({4{32'h12340000}}, {4{32'h00005678}}, '0, 4'hF);
        wait_done();
        check_eq("stall_nbeats", 128'(res_q.size()), 128'd3);
        if (res_q.size() == 3) begin
            check_eq("stall_beat1", res_q[0], {4{32'h33333333}});
            check_eq("stall_beat2", res_q[1], {4{32'hFFFFFFFF}});
            check_eq("stall_beat3", res_q[2], {4{32'h12345678}});
            check_eq("stall_last2", {127'd0, last_q[1]}, 128'd0);
            check_eq("stall_last3", {127'd0, last_q[2]}, 128'd1);
        end

        // vl=0: immediate done, no output beats.
        ov0 = ov_cnt;
        start_op(3'd0, 6'd0, 1'b0);
        check_eq("vl0_done", {127'd0, done}, 128'd1);
        check_eq("vl0_busy", {127'd0, busy}, 128'd0);
        tick();
        check_eq("vl0_done_pulse", {127'd0, done}, 128'd0);
        tick();
        check_eq("vl0_no_valid", 128'(ov_cnt - ov0), 128'd0);

        // start_i during RUN is ignored.
        clear_q();
        start_op(3'd0, 6'd4, 1'b0);
        start = 1'b1; op = 3'd2; vl = 6'd8;
        tick();
        start = 1'b0;
        send_beat({4{32'hF0F0F0F0}}, {4{32'hFF00FF00}}, '0, 4'hF);
        wait_done();
        check_eq("ign_nbeats", 128'(res_q.size()), 128'd1);
        if (res_q.size() == 1) check_eq("ign_result", res_q[0], {4{32'hF000F000}});
        check_eq("ign_idle", {127'd0, busy}, 128'd0);

        // Reset mid-operation after one beat.
        clear_q();
        out_ready = 1'b0;
        start_op(3'd0, 6'd8, 1'b0);
        send_beat({4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, '0, 4'hF);
        check_eq("mid_valid_before", {127'd0, out_valid}, 128'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid",    {127'd0, out_valid}, 128'd0);
        check_eq("mid_rst_busy",     {127'd0, busy},      128'd0);
        check_eq("mid_rst_in_ready", {127'd0, in_ready},  128'd0);
        check_eq("mid_rst_last",     {127'd0, out_last},  128'd0);
        check_eq("mid_rst_result",   result,              128'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        d0 = done_cnt;
        tick(); tick(); tick();
        check_eq("mid_rst_no_done", 128'(done_cnt - d0), 128'd0);
        clear_q();
        start_op(3'd4, 6'd8, 1'b0);
        send_beat({4{32'hAAAA5555}}, {4{32'hFFFF0000}}, '0, 4'hF);
        send_beat({4{32'h0000FFFF}}, {4{32'h00FF00FF}}, '0, 4'hF);
        wait_done();
        check_eq("post_rst_nbeats", 128'(res_q.size()), 128'd2);
        if (res_q.size() == 2) begin
            check_eq("post_rst_beat1", res_q[0], {4{32'h55555555}});
            check_eq("post_rst_beat2", res_q[1], {4{32'h00FFFF00}});
            check_eq("post_rst_last",  {127'd0, last_q[1]}, 128'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
